// File: rtl/flash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flash_pkg
// Description : Shared definitions for the SPI flash read front-end: FSM
//               state encoding, ROM bus widths and write_en encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package flash_pkg;

    localparam int ROM_ADDR_W = 16;
    localparam int ROM_DATA_W = 8;

    typedef logic [2:0] fsm_state_t;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_REQ    = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_DRAIN  = 3'd3;
    localparam logic [2:0] c_ST_FINISH = 3'd4;

    localparam logic c_WRITE_EN_READ  = 1'b0;
    localparam logic c_WRITE_EN_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous FIFO with a registered head word, registered
//               not-empty flag and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [WIDTH-1:0]   r_head;
    logic               r_valid;

    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_rd_next;
    logic [c_PTR_W:0]   w_count_next;

    assign w_push    = i_push && (r_count != c_FULL);
    assign w_pop     = i_pop && r_valid;
    assign w_rd_next = r_rd_ptr + 1'b1;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
            // Head tracks the next entry; with one entry left the incoming byte
            // lands in the slot after the head and must bypass the memory.
            if (w_pop) begin
                if (r_count > (c_PTR_W + 1)'(1)) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_push) begin
                    r_head <= i_data;
                end
            end else if (!r_valid && w_push) begin
                r_head <= i_data;
            end
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/flash_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : flash_stream_reader
// Description : Burst byte reader in front of the SPI flash controller; one
//               outstanding request, results streamed out through byte_fifo.
//               Optional watchdog abort enabled by defining ROM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_stream_reader
    import flash_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROM_ADDR_W-1:0] base_addr,
    input  logic [15:0]           length,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  rom_addr_en,
    output logic                  rom_write_en,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [ROM_DATA_W-1:0] rom_data,
    input  logic                  rom_data_ready,
    output logic [ROM_DATA_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int               c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("flash_stream_reader: DEPTH must be a power of two in 2..64");
    end
    if (TIMEOUT_CYCLES < 3) begin : g_bad_timeout
        $error("flash_stream_reader: TIMEOUT_CYCLES must be at least 3");
    end

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [ROM_ADDR_W-1:0] r_addr;
    logic [15:0]           r_remaining;
    logic                  r_done;

    logic                  w_start;
    logic                  w_free;
    logic                  w_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_timeout;
    logic [c_CNT_W-1:0]    w_count;

    assign w_start = start && (r_state == c_ST_IDLE);
    assign w_free  = (w_count < c_FULL);
    assign w_req   = (r_state == c_ST_REQ) && w_free;
    assign w_push  = (r_state == c_ST_WAIT) && rom_data_ready;
    assign w_pop   = out_valid && out_ready;

`ifdef ROM_TIMEOUT_EN
    localparam int                  c_WDOG_W     = $clog2(TIMEOUT_CYCLES + 1);
    // Request, FINISH and the registered done pulse account for the other
    // three cycles, so done lands TIMEOUT_CYCLES after the request.
    localparam logic [c_WDOG_W-1:0] c_WDOG_LIMIT = c_WDOG_W'(TIMEOUT_CYCLES - 3);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_error;

    assign w_timeout = (r_state == c_ST_WAIT) && !rom_data_ready && (r_wdog == c_WDOG_LIMIT);

    always_ff @(posedge clk) begin
        if (reset || r_state != c_ST_WAIT) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = (length == '0) ? c_ST_FINISH : c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (w_free) begin
                    w_state_next = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (rom_data_ready) begin
                    w_state_next = (r_remaining == 16'd1) ? c_ST_DRAIN : c_ST_REQ;
                end else if (w_timeout) begin
                    w_state_next = c_ST_FINISH;
                end
            end
            c_ST_DRAIN: begin
                if (w_count == '0) begin
                    w_state_next = c_ST_FINISH;
                end
            end
            c_ST_FINISH: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == c_ST_FINISH);
            if (w_start) begin
                r_addr      <= base_addr;
                r_remaining <= length;
            end else if (w_push) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ROM_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_timeout),
        .i_push  (w_push),
        .i_data  (rom_data),
        .i_pop   (w_pop),
        .o_head  (out_data),
        .o_valid (out_valid),
        .o_count (w_count)
    );

    // FINISH still counts as busy so that busy drops exactly as done rises.
    assign busy         = (r_state != c_ST_IDLE);
    assign done         = r_done;
    assign rom_addr_en  = w_req;
    assign rom_addr     = w_req ? r_addr : '0;
    assign rom_write_en = c_WRITE_EN_READ;

endmodule
`default_nettype wire

// File: tb/tb_flash_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_stream_reader
// Description : Scoreboard bench: controller model, random backpressure and a
//               queue-based expectation of request addresses and output bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_stream_reader;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        busy, done, error;
    logic        rom_addr_en, rom_write_en;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_data_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    flash_stream_reader #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .rom_addr_en    (rom_addr_en),
        .rom_write_en   (rom_write_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_data_ready (rom_data_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_addrs[$];

    int occ = 0;
    bit outstanding = 0;
    int n_done = 0;
    int n_req = 0;
    int cyc = 0;
    int req_cyc = 0;
    int done_cyc = 0;

    int ctl_lat_min = 1;
    int ctl_lat_max = 4;
    bit ctl_mute = 0;
    int inject_req = 0;
    int inject_done = 0;
    int ready_mode = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_bytes.delete();
                exp_addrs.delete();
                occ = 0;
                outstanding = 0;
            end else begin
                bit pop;
                bit push;
                pop  = out_valid && out_ready;
                push = rom_data_ready && outstanding;
                check("out_valid_vs_model", 32'(out_valid), 32'(occ != 0));
                if (rom_addr_en) begin
                    n_req++;
                    req_cyc = cyc;
                    check("req_with_free_entry", 32'(occ < DEPTH), 1);
                    check("write_en", 32'(rom_write_en), 0);
                    if (exp_addrs.size() == 0) check("unexpected_request", 32'(rom_addr_en), 0);
                    else check("rom_addr", 32'(rom_addr), 32'(exp_addrs.pop_front()));
                    outstanding = 1;
                end
                if (push) begin
                    check("push_not_full", 32'(occ < DEPTH), 1);
                    outstanding = 0;
                end
                if (pop) begin
                    if (exp_bytes.size() == 0) check("unexpected_byte", 32'(out_valid), 0);
                    else check("out_data", 32'(out_data), 32'(exp_bytes.pop_front()));
                end
                occ = occ + (push ? 1 : 0) - (pop ? 1 : 0);
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                    outstanding = 0;
                end
            end
        end
    end

    // Flash controller model: replies with the low address byte
    initial begin
        logic [15:0] a;
        int lat;
        rom_data_ready = 1'b0;
        rom_data = 8'h00;
        forever begin
            @(negedge clk);
            if (inject_req != inject_done) begin
                inject_done++;
                @(posedge clk); #1;
                rom_data_ready = 1'b1;
                rom_data = 8'hAA;
                @(posedge clk); #1;
                rom_data_ready = 1'b0;
            end else if (rom_addr_en && !ctl_mute && !reset) begin
                a = rom_addr;
                lat = $urandom_range(ctl_lat_max, ctl_lat_min);
                repeat (lat) @(posedge clk);
                #1;
                rom_data_ready = 1'b1;
                rom_data = a[7:0];
                @(posedge clk); #1;
                rom_data_ready = 1'b0;
            end
        end
    end

    // Consumer
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    task automatic issue(input logic [15:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        length = n;
        for (int i = 0; i < int'(n); i++) begin
            logic [15:0] a;
            a = b + 16'(i);
            exp_addrs.push_back(a);
            exp_bytes.push_back(a[7:0]);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int limit);
        for (int i = 0; i < limit && n_done == d0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check({name, "_done_count"}, 32'(n_done - d0), 1);
        check({name, "_bytes_left"}, 32'(exp_bytes.size()), 0);
        check({name, "_addrs_left"}, 32'(exp_addrs.size()), 0);
        check({name, "_busy_after"}, 32'(busy), 0);
        check({name, "_error_after"}, 32'(error), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_done"}, 32'(done), 0);
        check({name, "_error"}, 32'(error), 0);
        check({name, "_addr_en"}, 32'(rom_addr_en), 0);
        check({name, "_write_en"}, 32'(rom_write_en), 0);
        check({name, "_rom_addr"}, 32'(rom_addr), 0);
        check({name, "_out_data"}, 32'(out_data), 0);
        check({name, "_out_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        int d0;
        int r0;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Normal burst, fixed 3-cycle controller latency
        ctl_lat_min = 3; ctl_lat_max = 3; ready_mode = 1;
        d0 = n_done; r0 = n_req;
        issue(16'h0010, 16'd4);
        @(negedge clk);
        check("normal_req_cycle1", 32'(rom_addr_en), 1);
        check("normal_busy_cycle1", 32'(busy), 1);
        wait_done("normal", d0, 200);
        check("normal_req_count", 32'(n_req - r0), 4);

        // Backpressure: consumer stalled for 50 cycles
        ctl_lat_min = 1; ctl_lat_max = 4; ready_mode = 0;
        d0 = n_done; r0 = n_req;
        issue(16'h2000, 16'd10);
        repeat (50) @(posedge clk);
        check("bp_req_stall", 32'(n_req - r0), DEPTH);
        check("bp_busy", 32'(busy), 1);
        ready_mode = 1;
        wait_done("bp", d0, 300);
        check("bp_req_count", 32'(n_req - r0), 10);

        // Address wrap
        d0 = n_done;
        issue(16'hFFFE, 16'd3);
        wait_done("wrap", d0, 200);

        // Zero length: done in cycle 2, no request
        d0 = n_done; r0 = n_req;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h1234; length = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zl_busy_c1", 32'(busy), 1);
        check("zl_done_c1", 32'(done), 0);
        @(negedge clk);
        check("zl_done_c2", 32'(done), 1);
        check("zl_busy_c2", 32'(busy), 0);
        @(negedge clk);
        check("zl_done_c3", 32'(done), 0);
        check("zl_no_request", 32'(n_req - r0), 0);

        // start while busy is ignored
        ready_mode = 2;
        d0 = n_done;
        issue(16'h3000, 16'd8);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 16'h5555; length = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("midstart", d0, 300);

        // Randomized bursts
        for (int k = 0; k < 8; k++) begin
            logic [15:0] b;
            logic [15:0] n;
            b = (k % 3 == 0) ? 16'hFFF8 + 16'($urandom_range(7, 0)) : 16'($urandom);
            n = 16'($urandom_range(20, 1));
            d0 = n_done;
            issue(b, n);
            wait_done("random", d0, 600);
        end

        // Reset while waiting for a reply, then a late reply
        ctl_mute = 1; ready_mode = 1;
        r0 = n_req;
        issue(16'h0100, 16'd5);
        for (int i = 0; i < 20 && n_req == r0; i++) @(posedge clk);
        check("rst_req_seen", 32'(n_req - r0), 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        inject_req++;
        repeat (4) begin
            @(negedge clk);
            check("late_reply_out_valid", 32'(out_valid), 0);
            check("late_reply_busy", 32'(busy), 0);
        end
        ctl_mute = 0;

`ifdef ROM_TIMEOUT_EN
        // Watchdog: controller never answers
        ctl_mute = 1;
        d0 = n_done;
        issue(16'h4000, 16'd2);
        for (int i = 0; i < 100 && n_done == d0; i++) @(posedge clk);
        check("tmo_done", 32'(n_done - d0), 1);
        check("tmo_latency", 32'(done_cyc - req_cyc), TMO);
        check("tmo_error", 32'(error), 1);
        check("tmo_fifo_empty", 32'(out_valid), 0);
        exp_addrs.delete();
        exp_bytes.delete();
        ctl_mute = 0;
        d0 = n_done;
        issue(16'h4100, 16'd2);
        @(negedge clk);
        check("tmo_error_cleared", 32'(error), 0);
        wait_done("tmo_next", d0, 200);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_stream_reader.md
# flash_stream_reader

Sequential read front-end for the SPI flash controller. Given a base address and byte count, it issues one-byte read requests to the controller over its `addr_en`/`addr` strobe interface. It captures each returned byte on `data_ready` into a small FIFO and presents the stream to a downstream consumer with valid/ready flow control. It sits directly upstream of the flash controller and turns it into a burst byte source for loaders such as the bitmap/user-data fetch path.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `TIMEOUT_CYCLES`, 1024: cycles allowed per byte before abort. Used only with `ROM_TIMEOUT_EN`.

Ports:
- `clk`  in  1: single clock for everything.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle pulse; sampled only when `busy`=0.
- `base_addr`  in  16: first byte address, captured on `start`.
- `length`  in  16: number of bytes to read, captured on `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle pulse when the burst ends, whether completed or aborted.
- `error`  out  1: sticky timeout flag; cleared by the next accepted `start`.
- `rom_addr_en`  out  1: one-cycle request strobe to the controller.
- `rom_write_en`  out  1: held 0 (read only).
- `rom_addr`  out  16: request address, valid while `rom_addr_en`=1.
- `rom_data`  in  8: byte returned by the controller.
- `rom_data_ready`  in  1: one-cycle pulse qualifying `rom_data`.
- `out_data`  out  8: head of the FIFO.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: consumer accepts `out_data` when `out_valid`&&`out_ready`.

## Operation
- Reset value is 0 for every output. FSM goes to IDLE, the FIFO is emptied, and all counters are cleared.
- FSM states:
  - IDLE: on `start`, latch `base_addr` and `length`, then go to REQ. If `length`=0, go to FINISH instead.
  - REQ: wait until the number of free FIFO entries is at least 1, then assert `rom_addr_en` with `rom_addr`=current address and go to WAIT. Only one request is outstanding at any time.
  - WAIT: on `rom_data_ready`, push `rom_data`, increment the address, and decrement the remaining count. If remaining is not 0, go back to REQ; otherwise go to DRAIN.
  - DRAIN: stay until the FIFO is empty, then go to FINISH.
  - FINISH: pulse `done` and return to IDLE.
- The address increments modulo 2^16, so 16'hFFFF wraps to 16'h0000 with no flag raised.
- The remaining count is 16 bits; `length`=16'hFFFF is legal.
- `rom_data_ready` outside WAIT is ignored and does not push.
- The FIFO never overflows, because a request is issued only when at least one entry is free.
- FIFO push and pop in the same cycle are both honoured and the occupancy is unchanged.
- `start` while `busy`=1 is ignored.
- `reset` asserted mid-burst aborts immediately:
  - No `done` pulse is produced.
  - A controller reply that arrives after reset deasserts is ignored, because the FSM is in IDLE.

## Timing
- Cycle 0: `start` is sampled.
- Cycle 1: `busy`=1 and the FSM is in REQ. With a free entry, `rom_addr_en`=1 in this same cycle.
- Back-to-back requests are spaced at least 2 cycles apart: a reply in cycle N means the next `rom_addr_en` is in cycle N+1 at the earliest.
- A byte pushed on `rom_data_ready` in cycle N is visible on `out_data`/`out_valid` in cycle N+1.
- `done` is high for exactly 1 cycle. `busy` falls in the same cycle that `done` rises.
- For `length`=0: `done` in cycle 2, and no request is ever issued.
- A pop (`out_valid`&&`out_ready`) takes effect at the next clock edge.

## Configuration
- `ROM_TIMEOUT_EN` defined:
  - A watchdog counter runs in WAIT and restarts on each entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `rom_data_ready`: set `error`, flush the FIFO, and go to FINISH.
- `ROM_TIMEOUT_EN` undefined:
  - There is no counter, and `error` is tied to 0.
  - WAIT waits indefinitely for `rom_data_ready`.

## Structure
- Shared package `flash_pkg` holds:
  - the FSM state encoding (IDLE, REQ, WAIT, DRAIN, FINISH);
  - `ROM_ADDR_W`=16 and `ROM_DATA_W`=8;
  - the read/write encoding of `write_en`.
- One sub-module, `byte_fifo`: synchronous FIFO, parameterised by `DEPTH`, with registered output and an occupancy count. The free-entry check is derived from its occupancy count.

## Test plan
- Normal burst:
  - Stimulus: `base_addr`=16'h0010, `length`=4; a controller model replies 3 cycles after each request with data = low address byte; `out_ready`=1.
  - Required response: bytes 10,11,12,13 in order; exactly 4 `rom_addr_en` pulses; one `done` pulse.
- Backpressure:
  - Stimulus: `DEPTH`=4, `length`=10, `out_ready`=0 for 50 cycles, then 1.
  - Required response: requests stall after 4 bytes, no push is ever made with the FIFO full, and all 10 bytes arrive in order.
- Address wrap:
  - Stimulus: `base_addr`=16'hFFFE, `length`=3.
  - Required response: `rom_addr` sequence FFFE, FFFF, 0000.
- Zero length and `start` while busy:
  - Stimulus: `length`=0; then a second `start` issued mid-burst.
  - Required response: `done` in cycle 2 with no request issued; the mid-burst `start` is ignored.
- Reset mid-burst:
  - Stimulus: assert `reset` while the FSM is in WAIT, then deliver a late `rom_data_ready`.
  - Required response: all outputs are 0 and `out_valid` stays 0 after the late reply.
- Timeout (`ROM_TIMEOUT_EN`):
  - Stimulus: `TIMEOUT_CYCLES`=16, and the controller never replies.
  - Required response: `error`=1, `done` pulses 16 cycles after the request, and the FIFO is empty.
